grf_sb: RTL and testbench

- Parametrised general-register file for the pipelined MIPS core, replacing the fixed 2-read/1-write, 32x32 file.
- Provides NUM_RD read ports, one write-back port with write-through bypass, and register 0 hardwired to zero.
- Adds a per-register pending-write scoreboard: issue increments the counter, write-back decrements it. Read ports report busy so hazard logic can stall without its own tracking.

---
 rtl/grf_pkg.sv | 15 +
 rtl/grf_sb_cnt.sv | 53 +++++
 rtl/grf_sb.sv | 132 +++++++++++++
 tb/tb_grf_sb.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
// grf_pkg: shared defaults for the general-register file with scoreboard.
//   DATA_W / ADDR_W / CNT_W : default register, address and counter widths
//   ZERO_REG                : address of the hardwired-zero register
//   cnt_t                   : pending-write counter type at default width
package grf_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned CNT_W  = 2;

   localparam logic [ADDR_W-1:0] ZERO_REG = '0;

   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/grf_sb_cnt.sv
// grf_sb_cnt: pending-write counter for one architectural register.
// Ports:
//   Clk, Reset_n : clock (rising edge), asynchronous active-low reset
//   Inc          : accepted issue to this register (already gated by IssReady)
//   WbHit        : write-back addressed to this register this cycle
//   Flush        : clear the counter on the next edge, overriding Inc/WbHit
//   Dec          : WbHit retires an outstanding write (counter nonzero)
//   Under        : WbHit with nothing outstanding
//   Full         : counter saturated
//   Busy         : registered counter nonzero
//   Pend         : counter still nonzero after this cycle's retirement
module grf_sb_cnt #(
   parameter int unsigned CNT_W = $bits(grf_pkg::cnt_t)
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic Inc,
   input  logic WbHit,
   input  logic Flush,
   output logic Dec,
   output logic Under,
   output logic Full,
   output logic Busy,
   output logic Pend
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   always_comb begin
      Dec     = WbHit & (cnt != '0);
      Under   = WbHit & (cnt == '0);
      Full    = (cnt == '1);
      Busy    = (cnt != '0);
      Pend    = ((cnt - CNT_W'(Dec)) != '0);
      cnt_nxt = cnt;
      if (Flush) begin
         cnt_nxt = '0;
      end else begin
         // Inc on a full counter only arrives together with Dec, so no wrap.
         cnt_nxt = cnt + CNT_W'(Inc) - CNT_W'(Dec);
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/grf_sb.sv
// grf_sb: parametrised general-register file with pending-write scoreboard.
// Register 0 reads as zero; one write-back port with write-through bypass;
// NUM_RD combinational read ports, each reporting whether its register still
// has an outstanding write.
// Ports:
//   Clk, Reset_n        : clock (rising edge), asynchronous active-low reset
//   RAddr / RData / RBusy : read addresses, data and busy flags, port k sliced
//                         [k*ADDR_W +: ADDR_W] / [k*DATA_W +: DATA_W] / [k]
//   IssValid / IssAddr / IssReady : issue handshake marking a register pending
//   RegWrite / WAddr / WData      : write-back port
//   Flush   : clear all pending counters (data unaffected)
//   AnyBusy : some registered counter nonzero
//   Err     : sticky, write-back to a nonzero register with nothing pending
// Optional: define GRF_WRITE_LOG_EN to print "$<addr> <= <data>" on each
// write-back edge (simulation trace only).
module grf_sb #(
   parameter int unsigned DATA_W = grf_pkg::DATA_W,
   parameter int unsigned ADDR_W = grf_pkg::ADDR_W,
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned CNT_W  = grf_pkg::CNT_W
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic [NUM_RD*ADDR_W-1:0] RAddr,
   output logic [NUM_RD*DATA_W-1:0] RData,
   output logic [NUM_RD-1:0]        RBusy,
   input  logic                     IssValid,
   input  logic [ADDR_W-1:0]        IssAddr,
   output logic                     IssReady,
   input  logic                     RegWrite,
   input  logic [ADDR_W-1:0]        WAddr,
   input  logic [DATA_W-1:0]        WData,
   input  logic                     Flush,
   output logic                     AnyBusy,
   output logic                     Err
);

   import grf_pkg::*;

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  dec_v, under_v, full_v, busy_v, pend_v, inc_v, wbhit_v;
   logic              err_q;

   // Register 0 has no counter: it never pends, fills or underflows.
   assign dec_v[0]   = 1'b0;
   assign under_v[0] = 1'b0;
   assign full_v[0]  = 1'b0;
   assign busy_v[0]  = 1'b0;
   assign pend_v[0]  = 1'b0;
   assign inc_v[0]   = 1'b0;
   assign wbhit_v[0] = 1'b0;

   genvar r;
   generate
      for (r = 1; r < DEPTH; r++) begin : g_cnt
         assign wbhit_v[r] = RegWrite & (WAddr == ADDR_W'(r));
         assign inc_v[r]   = IssValid & IssReady & (IssAddr == ADDR_W'(r));

         grf_sb_cnt #(
            .CNT_W (CNT_W)
         ) u_cnt (
            .Clk     (Clk),
            .Reset_n (Reset_n),
            .Inc     (inc_v[r]),
            .WbHit   (wbhit_v[r]),
            .Flush   (Flush),
            .Dec     (dec_v[r]),
            .Under   (under_v[r]),
            .Full    (full_v[r]),
            .Busy    (busy_v[r]),
            .Pend    (pend_v[r])
         );
      end
   endgenerate

   // A saturated destination is accepted when the same cycle retires one.
   always_comb begin
      IssReady = !Flush & ((IssAddr == ADDR_W'(ZERO_REG)) | !full_v[IssAddr] | dec_v[IssAddr]);
   end

   always_comb begin
      logic [ADDR_W-1:0] ra;
      ra    = '0;
      RData = '0;
      RBusy = '0;
      for (int unsigned k = 0; k < NUM_RD; k++) begin
         ra = RAddr[k*ADDR_W +: ADDR_W];
         if (ra == ADDR_W'(ZERO_REG)) begin
            RData[k*DATA_W +: DATA_W] = '0;
         end else if (RegWrite && (ra == WAddr)) begin
            RData[k*DATA_W +: DATA_W] = WData;
         end else begin
            RData[k*DATA_W +: DATA_W] = regs[ra];
         end
         RBusy[k] = pend_v[ra];
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (RegWrite && (WAddr != ADDR_W'(ZERO_REG))) begin
         regs[WAddr] <= WData;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         err_q <= 1'b0;
      end else if (|under_v) begin
         err_q <= 1'b1;
      end
   end

   assign Err     = err_q;
   assign AnyBusy = |busy_v;

`ifdef GRF_WRITE_LOG_EN
   always_ff @(posedge Clk) begin
      if (Reset_n && RegWrite) begin
         $display("$%d <= %h", WAddr, WData);
      end
   end
`else
   // No write trace in the default build.
`endif

endmodule

// File: tb/tb_grf_sb.sv
module tb_grf_sb;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NUM_RD = 2;
   localparam int CNT_W  = 2;
   localparam int DEPTH  = 32;
   localparam int MAXC   = 3;

   logic                     Clk;
   logic                     Reset_n;
   logic [NUM_RD*ADDR_W-1:0] RAddr;
   logic [NUM_RD*DATA_W-1:0] RData;
   logic [NUM_RD-1:0]        RBusy;
   logic                     IssValid;
   logic [ADDR_W-1:0]        IssAddr;
   logic                     IssReady;
   logic                     RegWrite;
   logic [ADDR_W-1:0]        WAddr;
   logic [DATA_W-1:0]        WData;
   logic                     Flush;
   logic                     AnyBusy;
   logic                     Err;

   grf_sb #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD),
      .CNT_W  (CNT_W)
   ) dut (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .RAddr    (RAddr),
      .RData    (RData),
      .RBusy    (RBusy),
      .IssValid (IssValid),
      .IssAddr  (IssAddr),
      .IssReady (IssReady),
      .RegWrite (RegWrite),
      .WAddr    (WAddr),
      .WData    (WData),
      .Flush    (Flush),
      .AnyBusy  (AnyBusy),
      .Err      (Err)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      int          id;
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic [1:0]  rbusy;
      logic        issready;
      logic        anybusy;
      logic        err;
   } exp_t;

   exp_t        q[$];
   bit          stim_done = 1'b0;
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;

   // Reference model: architectural registers and outstanding-write counts.
   logic [31:0] m_reg [DEPTH];
   int          m_cnt [DEPTH];
   bit          m_err;

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_reg[i] = '0;
         m_cnt[i] = 0;
      end
      m_err = 1'b0;
   endtask

   // Drive one cycle's inputs just after the rising edge, queue the expected
   // outputs for that cycle, then advance the model across the next edge.
   task automatic do_cycle(input bit iv, input int ia, input bit rw, input int wa,
                           input logic [31:0] wd, input bit fl,
                           input int ra0, input int ra1, input bit rst);
      exp_t        e;
      int          ra[2];
      logic [31:0] d;
      bit          busy;
      bit          dec_ok;
      bit          acc;
      IssValid = iv;
      IssAddr  = ADDR_W'(ia);
      RegWrite = rw;
      WAddr    = ADDR_W'(wa);
      WData    = wd;
      Flush    = fl;
      RAddr    = {ADDR_W'(ra1), ADDR_W'(ra0)};
      Reset_n  = !rst;
      if (rst) model_reset();
      ra[0] = ra0;
      ra[1] = ra1;
      e.id = cyc;
      e.rbusy = '0;
      e.rd0 = '0;
      e.rd1 = '0;
      for (int k = 0; k < 2; k++) begin
         if (ra[k] == 0) d = '0;
         else if (rw && wa == ra[k]) d = wd;
         else d = m_reg[ra[k]];
         busy = (ra[k] != 0) &&
                ((m_cnt[ra[k]] - ((rw && wa == ra[k] && m_cnt[ra[k]] > 0) ? 1 : 0)) > 0);
         if (k == 0) e.rd0 = d; else e.rd1 = d;
         e.rbusy[k] = busy;
      end
      acc = !fl && (ia == 0 || m_cnt[ia] < MAXC || (rw && wa == ia && m_cnt[ia] > 0));
      e.issready = acc;
      e.anybusy = 1'b0;
      for (int i = 1; i < DEPTH; i++) if (m_cnt[i] != 0) e.anybusy = 1'b1;
      e.err = m_err;
      q.push_back(e);
      if (!rst) begin
         dec_ok = rw && wa != 0 && m_cnt[wa] > 0;
         if (rw && wa != 0) begin
            m_reg[wa] = wd;
            if (m_cnt[wa] == 0) m_err = 1'b1;
         end
         if (fl) begin
            for (int i = 0; i < DEPTH; i++) m_cnt[i] = 0;
         end else begin
            if (iv && acc && ia != 0) m_cnt[ia] = m_cnt[ia] + 1;
            if (dec_ok) m_cnt[wa] = m_cnt[wa] - 1;
         end
      end
      cyc++;
      @(posedge Clk);
      #1;
   endtask

   // Monitor: pops one expectation per cycle and compares mid-cycle.
   initial begin
      exp_t e;
      int   budget;
      budget = 0;
      forever begin
         @(negedge Clk);
         budget++;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (RData[31:0] !== e.rd0) begin
               errors++;
               $display("FAIL rdata0 cycle %0d: got %h expected %h", e.id, RData[31:0], e.rd0);
            end
            checks++;
            if (RData[63:32] !== e.rd1) begin
               errors++;
               $display("FAIL rdata1 cycle %0d: got %h expected %h", e.id, RData[63:32], e.rd1);
            end
            checks++;
            if (RBusy !== e.rbusy) begin
               errors++;
               $display("FAIL rbusy cycle %0d: got %b expected %b", e.id, RBusy, e.rbusy);
            end
            checks++;
            if (IssReady !== e.issready) begin
               errors++;
               $display("FAIL issready cycle %0d: got %b expected %b", e.id, IssReady, e.issready);
            end
            checks++;
            if (AnyBusy !== e.anybusy) begin
               errors++;
               $display("FAIL anybusy cycle %0d: got %b expected %b", e.id, AnyBusy, e.anybusy);
            end
            checks++;
            if (Err !== e.err) begin
               errors++;
               $display("FAIL err cycle %0d: got %b expected %b", e.id, Err, e.err);
            end
         end else if (stim_done) begin
            break;
         end
         if (budget > 5000) begin
            errors++;
            $display("FAIL timeout: got %0d cycles, expected at most 5000", budget);
            break;
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      Reset_n  = 1'b0;
      IssValid = 1'b0;
      IssAddr  = '0;
      RegWrite = 1'b0;
      WAddr    = '0;
      WData    = '0;
      Flush    = 1'b0;
      RAddr    = '0;
      model_reset();
      @(posedge Clk);
      #1;
      // iv ia rw wa wd fl ra0 ra1 rst
      do_cycle(0, 0, 0, 0, 32'h0, 0, 0, 0, 1);
      do_cycle(0, 0, 0, 0, 32'h0, 0, 5, 7, 1);
      // write $5 after issuing it, then read on both ports
      do_cycle(1, 5, 0, 0, 32'h0, 0, 5, 5, 0);
      do_cycle(0, 0, 1, 5, 32'hDEADBEEF, 0, 5, 5, 0);
      do_cycle(0, 0, 0, 0, 32'h0, 0, 5, 5, 0);
      // bypass on $7, then write $0 is ignored
      do_cycle(1, 7, 0, 0, 32'h0, 0, 0, 0, 0);
      do_cycle(0, 0, 1, 7, 32'h12345678, 0, 7, 0, 0);
      do_cycle(0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 7, 0);
      do_cycle(0, 0, 0, 0, 32'h0, 0, 0, 7, 0);
      // saturate $3, rejected fourth issue, accepted with same-cycle retire
      for (int i = 0; i < 4; i++) do_cycle(1, 3, 0, 0, 32'h0, 0, 3, 0, 0);
      do_cycle(1, 3, 1, 3, 32'h33, 0, 3, 0, 0);
      for (int i = 0; i < 3; i++) do_cycle(0, 0, 1, 3, 32'h300 + i, 0, 3, 3, 0);
      // last outstanding write to $9 reads not busy in its own cycle
      do_cycle(1, 9, 0, 0, 32'h0, 0, 0, 9, 0);
      do_cycle(0, 0, 1, 9, 32'h99, 0, 0, 9, 0);
      do_cycle(0, 0, 0, 0, 32'h0, 0, 9, 9, 0);
      // underflow on $4 sets sticky Err
      do_cycle(0, 0, 1, 4, 32'h44, 0, 4, 0, 0);
      do_cycle(0, 0, 0, 0, 32'h0, 0, 4, 0, 0);
      do_cycle(0, 0, 0, 0, 32'h0, 0, 4, 0, 0);
      // flush with a pending issue, then asynchronous reset mid-cycle
      do_cycle(1, 2, 0, 0, 32'h0, 0, 2, 6, 0);
      do_cycle(1, 6, 0, 0, 32'h0, 0, 2, 6, 0);
      do_cycle(1, 8, 1, 6, 32'h66, 1, 2, 6, 0);
      do_cycle(0, 0, 0, 0, 32'h0, 0, 8, 6, 0);
      do_cycle(1, 2, 0, 0, 32'h0, 0, 2, 5, 0);
      do_cycle(0, 0, 0, 0, 32'h0, 0, 2, 5, 1);
      do_cycle(0, 0, 0, 0, 32'h0, 0, 2, 5, 0);
      // randomized traffic on a small address window to force collisions
      for (int n = 0; n < 600; n++) begin
         do_cycle($urandom_range(0, 9) < 6, $urandom_range(0, 7),
                  $urandom_range(0, 9) < 4, $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 24) == 0,
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 149) == 0);
      end
      stim_done = 1'b1;
   end

endmodule
